// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: load-use stall detection and EX operand forwarding for a 5-stage pipeline.
// EX/MEM/WB shadow records track each in-flight instruction's register usage.
module hazard_fwd_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic [4:0]  id_dst,
  input  logic        id_regwrite,
  input  logic        id_memread,
  input  logic        flush,
  output logic [1:0]  fwd_a_sel,
  output logic [1:0]  fwd_b_sel,
  output logic        stall,
  output logic [15:0] stall_cnt
);
  typedef struct packed {
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
    logic [4:0] dst;
    logic       regwrite;
    logic       memread;
  } rec_t;

  rec_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  function automatic logic hit(input rec_t p, input logic u, input logic [4:0] r);
    return p.valid && p.regwrite && p.dst != 5'd0 && u && p.dst == r;
  endfunction

  always_comb begin
    stall = ex_q.valid && ex_q.memread && ex_q.dst != 5'd0 && !flush &&
            ((id_use_rs && id_rs == ex_q.dst) || (id_use_rt && id_rt == ex_q.dst));
    fwd_a_sel = !ex_q.valid ? 2'd0 : hit(mem_q, ex_q.use_rs, ex_q.rs) ? 2'd1 :
                hit(wb_q, ex_q.use_rs, ex_q.rs) ? 2'd2 : 2'd0;
    fwd_b_sel = !ex_q.valid ? 2'd0 : hit(mem_q, ex_q.use_rt, ex_q.rt) ? 2'd1 :
                hit(wb_q, ex_q.use_rt, ex_q.rt) ? 2'd2 : 2'd0;
    ex_d = (stall || flush) ? rec_t'('0) :
           rec_t'({1'b1, id_rs, id_rt, id_use_rs, id_use_rt, id_dst, id_regwrite, id_memread});
    mem_d = ex_q;
    wb_d = mem_q;
    stall_cnt_d = (stall && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// tb_hazard_fwd_ctrl: directed scenarios plus random traffic checked against a stage-list model.
module tb_hazard_fwd_ctrl;
  logic clk = 1'b0;
  logic rst, id_use_rs, id_use_rt, id_regwrite, id_memread, flush, stall;
  logic [4:0] id_rs, id_rt, id_dst;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic [15:0] stall_cnt;

  hazard_fwd_ctrl dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .id_dst(id_dst), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .flush(flush), .fwd_a_sel(fwd_a_sel),
    .fwd_b_sel(fwd_b_sel), .stall(stall), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit v;
    int rs;
    int rt;
    bit urs;
    bit urt;
    int dst;
    bit rw;
    bit mr;
  } ins_t;

  // st[0]=EX, st[1]=MEM, st[2]=WB; index is also the forwarding distance
  ins_t st[3];
  int cnt;
  ins_t cur;
  bit cur_fl, cur_rst;

  function automatic ins_t mk(int rs, int rt, bit urs, bit urt, int dst, bit rw, bit mr);
    ins_t i;
    i.v = 1; i.rs = rs; i.rt = rt; i.urs = urs; i.urt = urt;
    i.dst = dst; i.rw = rw; i.mr = mr;
    return i;
  endfunction

  function automatic int m_sel(bit a_side);
    int r = a_side ? st[0].rs : st[0].rt;
    bit u = a_side ? st[0].urs : st[0].urt;
    if (!st[0].v || !u || r == 0) return 0;
    for (int s = 1; s < 3; s++)
      if (st[s].v && st[s].rw && st[s].dst == r) return s;
    return 0;
  endfunction

  function automatic bit m_stall();
    if (cur_fl || !st[0].v || !st[0].mr || st[0].dst == 0) return 0;
    return (cur.urs && cur.rs == st[0].dst) || (cur.urt && cur.rt == st[0].dst);
  endfunction

  task automatic drive(input ins_t i, input bit fl, input bit r);
    cur = i; cur_fl = fl; cur_rst = r;
    id_rs = 5'(i.rs); id_rt = 5'(i.rt); id_use_rs = i.urs; id_use_rt = i.urt;
    id_dst = 5'(i.dst); id_regwrite = i.rw; id_memread = i.mr;
    flush = fl; rst = r;
    #1;
  endtask

  task automatic tick();
    bit s = m_stall();
    ins_t bub = '{default: 0};
    @(posedge clk);
    if (cur_rst) begin
      for (int k = 0; k < 3; k++) st[k] = bub;
      cnt = 0;
    end else begin
      st[2] = st[1];
      st[1] = st[0];
      st[0] = (s || cur_fl) ? bub : cur;
      if (s && cnt < 65535) cnt++;
    end
    @(negedge clk);
  endtask

  task automatic nops(input int n);
    for (int k = 0; k < n; k++) begin
      drive(mk(0, 0, 0, 0, 0, 0, 0), 0, 0);
      tick();
    end
  endtask

  task automatic test_reset();
    drive(mk(0, 0, 0, 0, 0, 0, 0), 0, 1);
    tick();
    drive(mk(0, 0, 0, 0, 0, 0, 0), 0, 0);
    checks += 4;
    if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b want 0", stall); end
    if (fwd_a_sel !== 2'd0) begin errors++; $display("FAIL reset_fwd_a got %0d want 0", fwd_a_sel); end
    if (fwd_b_sel !== 2'd0) begin errors++; $display("FAIL reset_fwd_b got %0d want 0", fwd_b_sel); end
    if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", stall_cnt); end
  endtask

  task automatic test_forward_mem();
    nops(3);
    drive(mk(1, 2, 1, 1, 3, 1, 0), 0, 0); tick();
    drive(mk(3, 4, 1, 1, 6, 1, 0), 0, 0); tick();
    drive(mk(0, 0, 0, 0, 0, 0, 0), 0, 0);
    checks += 3;
    if (fwd_a_sel !== 2'd1) begin errors++; $display("FAIL fwd_mem_a got %0d want 1", fwd_a_sel); end
    if (fwd_b_sel !== 2'd0) begin errors++; $display("FAIL fwd_mem_b got %0d want 0", fwd_b_sel); end
    if (stall !== 1'b0) begin errors++; $display("FAIL fwd_mem_stall got %0b want 0", stall); end
  endtask

  task automatic test_load_use();
    int c0;
    nops(3);
    c0 = cnt;
    drive(mk(1, 0, 1, 0, 5, 1, 1), 0, 0); tick();
    drive(mk(2, 5, 1, 1, 8, 1, 0), 0, 0);
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %0b want 1", stall); end
    tick();
    drive(mk(2, 5, 1, 1, 8, 1, 0), 0, 0);
    checks += 2;
    if (stall !== 1'b0) begin errors++; $display("FAIL lu_one_cycle got %0b want 0", stall); end
    if (stall_cnt !== 16'(c0 + 1)) begin errors++; $display("FAIL lu_cnt got %0d want %0d", stall_cnt, c0 + 1); end
    tick();
    drive(mk(0, 0, 0, 0, 0, 0, 0), 0, 0);
    checks += 2;
    if (fwd_b_sel !== 2'd2) begin errors++; $display("FAIL lu_fwd_b got %0d want 2", fwd_b_sel); end
    if (fwd_a_sel !== 2'd0) begin errors++; $display("FAIL lu_fwd_a got %0d want 0", fwd_a_sel); end
  endtask

  task automatic test_both_match();
    nops(3);
    drive(mk(0, 0, 0, 0, 7, 1, 0), 0, 0); tick();
    drive(mk(0, 0, 0, 0, 7, 1, 0), 0, 0); tick();
    drive(mk(7, 7, 1, 1, 9, 1, 0), 0, 0); tick();
    drive(mk(0, 0, 0, 0, 0, 0, 0), 0, 0);
    checks += 2;
    if (fwd_a_sel !== 2'd1) begin errors++; $display("FAIL both_a got %0d want 1", fwd_a_sel); end
    if (fwd_b_sel !== 2'd1) begin errors++; $display("FAIL both_b got %0d want 1", fwd_b_sel); end
  endtask

  task automatic test_reg0();
    nops(3);
    drive(mk(1, 1, 1, 0, 0, 1, 1), 0, 0); tick();
    drive(mk(0, 0, 1, 1, 4, 1, 0), 0, 0);
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL r0_stall got %0b want 0", stall); end
    tick();
    drive(mk(0, 0, 0, 0, 0, 0, 0), 0, 0);
    checks += 2;
    if (fwd_a_sel !== 2'd0) begin errors++; $display("FAIL r0_fwd_a got %0d want 0", fwd_a_sel); end
    if (fwd_b_sel !== 2'd0) begin errors++; $display("FAIL r0_fwd_b got %0d want 0", fwd_b_sel); end
  endtask

  task automatic test_flush();
    int c0;
    nops(3);
    c0 = cnt;
    drive(mk(1, 0, 1, 0, 5, 1, 1), 0, 0); tick();
    drive(mk(2, 5, 1, 1, 8, 1, 0), 1, 0);
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall got %0b want 0", stall); end
    tick();
    drive(mk(0, 0, 0, 0, 0, 0, 0), 0, 0);
    checks += 3;
    if (stall_cnt !== 16'(c0)) begin errors++; $display("FAIL flush_cnt got %0d want %0d", stall_cnt, c0); end
    if (fwd_a_sel !== 2'd0) begin errors++; $display("FAIL flush_fwd_a got %0d want 0", fwd_a_sel); end
    if (fwd_b_sel !== 2'd0) begin errors++; $display("FAIL flush_fwd_b got %0d want 0", fwd_b_sel); end
  endtask

  task automatic test_saturate();
    ins_t ld = mk(5, 0, 1, 0, 5, 1, 1);
    nops(3);
    force dut.stall_cnt_q = 16'hFFFE;
    #1;
    release dut.stall_cnt_q;
    cnt = 65534;
    // a self-dependent load stalls every other cycle
    for (int k = 0; k < 6; k++) begin
      drive(ld, 0, 0);
      checks++;
      if (stall !== m_stall()) begin errors++; $display("FAIL sat_stall%0d got %0b want %0b", k, stall, m_stall()); end
      tick();
    end
    drive(ld, 0, 0);
    checks++;
    if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_cnt got %h want ffff", stall_cnt); end
    tick();
    drive(ld, 0, 1);
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL sat_pre_rst_stall got %0b want 1", stall); end
    tick();
    drive(ld, 0, 0);
    checks += 4;
    if (stall !== 1'b0) begin errors++; $display("FAIL sat_rst_stall got %0b want 0", stall); end
    if (stall_cnt !== 16'd0) begin errors++; $display("FAIL sat_rst_cnt got %h want 0", stall_cnt); end
    if (fwd_a_sel !== 2'd0) begin errors++; $display("FAIL sat_rst_fwd_a got %0d want 0", fwd_a_sel); end
    if (fwd_b_sel !== 2'd0) begin errors++; $display("FAIL sat_rst_fwd_b got %0d want 0", fwd_b_sel); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 500; k++) begin
      ins_t i = mk($urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom), 1'($urandom),
                   $urandom_range(0, 7), 1'($urandom), 1'($urandom_range(0, 2) == 0));
      drive(i, $urandom_range(0, 7) == 0, $urandom_range(0, 49) == 0);
      checks += 4;
      if (stall !== m_stall()) begin errors++; $display("FAIL rnd_stall@%0d got %0b want %0b", k, stall, m_stall()); end
      if (fwd_a_sel !== 2'(m_sel(1))) begin errors++; $display("FAIL rnd_fwd_a@%0d got %0d want %0d", k, fwd_a_sel, m_sel(1)); end
      if (fwd_b_sel !== 2'(m_sel(0))) begin errors++; $display("FAIL rnd_fwd_b@%0d got %0d want %0d", k, fwd_b_sel, m_sel(0)); end
      if (stall_cnt !== 16'(cnt)) begin errors++; $display("FAIL rnd_cnt@%0d got %0d want %0d", k, stall_cnt, cnt); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_forward_mem();
    test_load_use();
    test_both_match();
    test_reg0();
    test_flush();
    test_saturate();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_fwd_ctrl.md
HAZARD_FWD_CTRL -- requirements
Module: hazard_fwd_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have ports id_rs and id_rt, input, 5 bits each: source registers of the instruction in ID.
REQ-004 SHALL have ports id_use_rs and id_use_rt, input, 1 bit each: the ID instruction actually reads rs / rt.
REQ-005 SHALL have port id_dst, input, 5 bits: destination register of the ID instruction, already resolved by the dstreg mux.
REQ-006 SHALL have ports id_regwrite and id_memread, input, 1 bit each: the ID instruction writes a register / is a load.
REQ-007 SHALL have port flush, input, 1 bit: kill the ID instruction (branch/jump taken).
REQ-008 SHALL have ports fwd_a_sel and fwd_b_sel, output, 2 bits each: select for the EX operand A / B mux3to1; 0 = register file, 1 = EX/MEM result, 2 = MEM/WB result.
REQ-009 SHALL have port stall, output, 1 bit: hold PC and IF/ID, and inject a bubble into EX.
REQ-010 SHALL have port stall_cnt, output, 16 bits: number of load-use stall cycles taken.

Function
REQ-011 SHALL keep three internal stage records, EX, MEM and WB; each record holds {valid, rs, rt, use_rs, use_rt, dst, regwrite, memread}.
REQ-012 Each clock SHALL advance the records as WB<=MEM, MEM<=EX, EX<=ID inputs (with valid=1), except where REQ-013 or REQ-014 applies.
REQ-013 When stall=1, EX SHALL load a bubble (valid=0, regwrite=0, memread=0); MEM and WB SHALL advance normally.
REQ-014 When flush=1, EX SHALL load a bubble, stall SHALL be forced to 0, and MEM and WB SHALL advance normally; flush takes priority over stall.
REQ-015 stall SHALL be combinational and equal 1 iff EX.valid and EX.memread and EX.dst!=0 and ((id_use_rs and id_rs==EX.dst) or (id_use_rt and id_rt==EX.dst)) and not flush.
REQ-016 A load-use hazard SHALL produce exactly one stall cycle; in the next cycle the load is in MEM and forwarding from WB covers it.
REQ-017 fwd_a_sel SHALL be combinational from the records: 1 if MEM.valid and MEM.regwrite and MEM.dst!=0 and EX.use_rs and MEM.dst==EX.rs; else 2 if the same test passes with WB in place of MEM; else 0.
REQ-018 fwd_b_sel SHALL follow REQ-017 using EX.rt and EX.use_rt.
REQ-019 When both MEM and WB match, MEM SHALL win (youngest producer).
REQ-020 Register 0 SHALL never be forwarded or cause a stall.
REQ-021 A bubble in EX (valid=0) SHALL drive fwd_a_sel=fwd_b_sel=0.
REQ-022 fwd_*_sel SHALL never take the value 3.
REQ-023 stall_cnt SHALL increment by 1 on each clock edge where stall=1 and SHALL saturate at 16'hFFFF (no wrap).

Reset
REQ-024 On a clock edge with rst=1, all records SHALL clear to bubbles and stall_cnt SHALL clear to 0; after that edge, stall=0 and fwd_a_sel=fwd_b_sel=0.
REQ-025 rst SHALL take priority over stall and flush; an asserted rst mid-hazard SHALL discard all pending hazards.

Verification
REQ-026 add r3 (in EX), then sub with rs=r3 in ID; one clock later -> fwd_a_sel=1, stall=0.
REQ-027 lw r5, then add with rt=r5 -> stall=1 for exactly 1 cycle, stall_cnt=1; next cycle fwd_b_sel=2.
REQ-028 r7 written by both the MEM and WB records, EX reads r7 on both rs and rt -> fwd_a_sel=1, fwd_b_sel=1.
REQ-029 lw r0 followed by a reader of r0; also a write to r0 in MEM -> stall=0, fwd_*_sel=0.
REQ-030 Load-use hazard with flush=1 in the same cycle -> stall=0, stall_cnt unchanged, EX bubble next cycle (fwd_*_sel=0).
REQ-031 stall_cnt forced to 16'hFFFE, then 3 stall cycles -> reads 16'hFFFF; then rst pulse mid-stall -> stall_cnt=0 and stall=0 after the edge.
